lane_phase_controller: RTL and testbench
========================================

# lane_phase_controller

Parametrised successor to the Breadboard traffic sequencer. Serves N_LANES approach lanes one at a time in round-robin order. Each lane's green time scales with its queued car count, with separate day and night timing. Emergency preemption and a latched pedestrian phase are supported. The block sits between the lane-count sensors and the light drivers, and replaces the fixed 8-lane day/night/emergency/pedestrian load-time logic.

## Interface
Parameters:
- N_LANES, 8: number of lanes; one green output per lane.
- CNT_W, 8: width of each lane car count.
- TIME_W, 7: countdown width.
- DAY_GREEN, 8: base green cycles in day mode.
- NIGHT_GREEN, 4: base green cycles in night mode.
- SCALE_SH, 2: right shift applied to the car count before it is added to the base.
- MAX_GREEN, 60: green-time saturation limit.
- CLEAR_CYCLES, 3: all-red clearance length.
- PED_TIME, 10: walk phase length.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- hoursIn  in  5  hour of day, 0–23.
- pedSignal  in  1  pedestrian request; a one-cycle pulse is sufficient.
- emgSignal  in  1  emergency active (level).
- emgLane  in  N_LANES  lanes to turn green during an emergency.
- laneCounts  in  N_LANES*CNT_W  car counts; lane i occupies bits [i*CNT_W +: CNT_W].
- greenLights  out  N_LANES  one-hot during normal service; equals emgLane during an emergency.
- walkLights  out  N_LANES  all ones during the PED phase, otherwise zero.
- trafficMode  out  2  00 = day, 01 = night, 10 = emergency, 11 = pedestrian.
- currentCount  out  TIME_W  cycles remaining in the current timed state.

## Operation
- States:
  - ALL_RED (clearance)
  - GREEN
  - EMG
  - PED
- Day/night selection: day when 6 ≤ hoursIn ≤ 21. Night for every other value, including out-of-range values 24–31.
- Green time: T = min(MAX_GREEN, base + (count >> SCALE_SH)).
  - base is DAY_GREEN or NIGHT_GREEN.
  - count is the served lane's count, sampled at the ALL_RED→GREEN transition.
  - Use TIME_W+1-bit intermediate arithmetic. Clamp T to a minimum of 1.
- Decision at the end of ALL_RED, in priority order:
  1. emgSignal is high and emgLane ≠ 0 → EMG.
  2. Otherwise, pedPending → PED.
  3. Otherwise, GREEN for the next lane after lanePtr (wrapping N_LANES-1 → 0).
     - At night, skip lanes whose count is 0.
     - If every lane is 0 at night, stay in ALL_RED, reload CLEAR_CYCLES, and leave lanePtr unchanged.
- GREEN: when the countdown expires, go to ALL_RED. A valid emergency (emgSignal high, emgLane ≠ 0) aborts GREEN on the next edge and enters ALL_RED, which still runs its full CLEAR_CYCLES.
- EMG:
  - greenLights is the registered emgLane, updated every cycle.
  - currentCount = 0.
  - When emgSignal goes low, enter ALL_RED, then resume at lanePtr+1.
  - emgLane = 0 with emgSignal high: treated as no emergency.
- Pedestrian requests: pedSignal sets pedPending in any state except PED, where it is ignored. Entering PED clears pedPending. PED never preempts a running GREEN.
- PED: all greens 0, walkLights all ones, lasts PED_TIME cycles, then ALL_RED.
- Mode output: trafficMode reports day or night in ALL_RED and GREEN, 10 in EMG, 11 in PED.

## Timing
- All outputs are registered.
- A timed state loaded with T lasts exactly T cycles; currentCount shows T, T-1, …, 1 during it.
- The state changes on the edge after currentCount = 1.
- Reset values:
  - state ALL_RED
  - currentCount = CLEAR_CYCLES
  - lanePtr = N_LANES-1, so lane 0 is served first
  - greenLights = 0, walkLights = 0, trafficMode = 00, pedPending = 0
- Reset asserted mid-operation forces all reset values immediately, with no wait for a clock edge.
- If emgSignal and pedPending are both active at the ALL_RED decision, EMG wins and pedPending is held.

## Configuration
- PED_PHASE_EN defined: the PED state and pedPending exist as described above.
- PED_PHASE_EN undefined:
  - pedSignal is ignored.
  - walkLights is tied to 0.
  - The PED state is not synthesised.
  - trafficMode never reports 11.

## Structure
- Package traffic_pkg holds:
  - state encoding
  - trafficMode constants: MODE_DAY, MODE_NIGHT, MODE_EMG, MODE_PED
  - day window constants: DAY_START = 6, DAY_END = 21
- Sub-module phase_timer: loadable TIME_W down counter with load, value and expire ports, instanced once.

## Test plan
- Reset release, hoursIn = 12, all counts 0x10 → 3 cycles of all-red, then lane 0 green for 12 cycles (8 + 4), then 3 cycles of all-red, then lane 1 green.
- Lane 0 count 0xFF, day → 8 + 63 = 71 saturates, so lane 0 is green for exactly 60 cycles.
- hoursIn = 22, only lane 3 count 8 → lane 3 green for 6 cycles (4 + 2), then 3 cycles of all-red, then lane 3 again; with all counts 0, the block stays in ALL_RED indefinitely.
- emgSignal = 1 with emgLane = 8'b00001000 during lane 0 green:
  - Green drops on the next edge, then 3 cycles of all-red.
  - greenLights = 0x08, trafficMode = 10 until release.
  - After release: 3 cycles of all-red, then lane 1.
- One-cycle pedSignal pulse during lane 2 green → lane 2 completes normally, then 3 cycles of all-red, then walkLights = 0xFF with trafficMode = 11 for 10 cycles, then all-red, then lane 3. With PED_PHASE_EN undefined, the pulse has no effect.
- rst driven low mid-EMG, between clock edges → outputs reach reset values before the next edge; after release, lane 0 is served first.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state encoding, mode codes and day window for lane_phase_controller
package traffic_pkg;

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_EMG     = 2'd2,
    S_PED     = 2'd3
  } stateT;

  localparam logic [1:0] MODE_DAY   = 2'b00;
  localparam logic [1:0] MODE_NIGHT = 2'b01;
  localparam logic [1:0] MODE_EMG   = 2'b10;
  localparam logic [1:0] MODE_PED   = 2'b11;

  localparam logic [4:0] DAY_START = 5'd6;
  localparam logic [4:0] DAY_END   = 5'd21;

  // Out-of-range hours (24-31) fall outside the window and count as night.
  function automatic logic isDay(input logic [4:0] hours);
    return (hours >= DAY_START) && (hours <= DAY_END);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down counter timing each phase
// Holds at zero when not reloaded; expire flags the last cycle of a timed state.
module phase_timer #(
  parameter int TIME_W      = 7,
  parameter int RESET_VALUE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] loadValue,
  output logic [TIME_W-1:0] value,
  output logic              expire
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= TIME_W'(RESET_VALUE);
    end else if (load) begin
      value <= loadValue;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expire = (value == TIME_W'(1));

endmodule

// File: rtl/lane_phase_controller.sv
// rtl/lane_phase_controller.sv - round-robin lane sequencer with emergency and pedestrian phases
// Define PED_PHASE_EN to build the latched pedestrian walk phase.
module lane_phase_controller
  import traffic_pkg::*;
#(
  parameter int N_LANES      = 8,
  parameter int CNT_W        = 8,
  parameter int TIME_W       = 7,
  parameter int DAY_GREEN    = 8,
  parameter int NIGHT_GREEN  = 4,
  parameter int SCALE_SH     = 2,
  parameter int MAX_GREEN    = 60,
  parameter int CLEAR_CYCLES = 3,
  parameter int PED_TIME     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               hoursIn,
  input  logic                     pedSignal,
  input  logic                     emgSignal,
  input  logic [N_LANES-1:0]       emgLane,
  input  logic [N_LANES*CNT_W-1:0] laneCounts,
  output logic [N_LANES-1:0]       greenLights,
  output logic [N_LANES-1:0]       walkLights,
  output logic [1:0]               trafficMode,
  output logic [TIME_W-1:0]        currentCount
);

  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  stateT             state, nextState;
  logic [LANE_W-1:0] lanePtr, nextLanePtr;
  logic              pedPending;
  logic              timerLoad;
  logic [TIME_W-1:0] timerLoadValue;
  logic              expire;
  logic [N_LANES-1:0] nextGreen;
  logic [1:0]        nextMode;
  logic              emgValid;
  logic              dayMode;

  logic [CNT_W-1:0]  laneCnt [N_LANES];
  logic              laneFound;
  logic [LANE_W-1:0] candLane;
  logic [LANE_W:0]   candSum;
  logic [CNT_W-1:0]  shiftedCnt;
  logic [TIME_W:0]   shiftedSat, greenSum, greenTime;

  assign emgValid = emgSignal && (emgLane != '0);
  assign dayMode  = isDay(hoursIn);

  for (genvar i = 0; i < N_LANES; i++) begin : gCnt
    assign laneCnt[i] = laneCounts[i*CNT_W +: CNT_W];
  end

  // First lane after lanePtr eligible for service; night skips empty lanes.
  always_comb begin
    laneFound = 1'b0;
    candLane  = lanePtr;
    candSum   = '0;
    for (int k = 1; k <= N_LANES; k++) begin
      candSum = {1'b0, lanePtr} + (LANE_W+1)'(k);
      if (candSum >= (LANE_W+1)'(N_LANES)) candSum = candSum - (LANE_W+1)'(N_LANES);
      if (!laneFound && (dayMode || laneCnt[candSum[LANE_W-1:0]] != '0)) begin
        laneFound = 1'b1;
        candLane  = candSum[LANE_W-1:0];
      end
    end
  end

  always_comb begin
    shiftedCnt = laneCnt[candLane] >> SCALE_SH;
    shiftedSat = (shiftedCnt > CNT_W'(MAX_GREEN)) ? (TIME_W+1)'(MAX_GREEN)
                                                  : (TIME_W+1)'(shiftedCnt);
    greenSum   = (TIME_W+1)'(dayMode ? DAY_GREEN : NIGHT_GREEN) + shiftedSat;
    greenTime  = (greenSum > (TIME_W+1)'(MAX_GREEN)) ? (TIME_W+1)'(MAX_GREEN) : greenSum;
    if (greenTime == '0) greenTime = (TIME_W+1)'(1);
  end

  phase_timer #(
    .TIME_W      (TIME_W),
    .RESET_VALUE (CLEAR_CYCLES)
  ) uTimer (
    .clk       (clk),
    .rst       (rst),
    .load      (timerLoad),
    .loadValue (timerLoadValue),
    .value     (currentCount),
    .expire    (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_ALL_RED;
      lanePtr     <= LANE_W'(N_LANES-1);
      greenLights <= '0;
      trafficMode <= MODE_DAY;
    end else begin
      state       <= nextState;
      lanePtr     <= nextLanePtr;
      greenLights <= nextGreen;
      trafficMode <= nextMode;
    end
  end

  always_comb begin
    nextState      = state;
    nextLanePtr    = lanePtr;
    timerLoad      = 1'b0;
    timerLoadValue = TIME_W'(CLEAR_CYCLES);
    case (state)
      S_ALL_RED: begin
        if (expire) begin
          timerLoad = 1'b1;
          if (emgValid) begin
            nextState      = S_EMG;
            timerLoadValue = '0;
          end else if (pedPending) begin
            nextState      = S_PED;
            timerLoadValue = TIME_W'(PED_TIME);
          end else if (laneFound) begin
            nextState      = S_GREEN;
            nextLanePtr    = candLane;
            timerLoadValue = greenTime[TIME_W-1:0];
          end
        end
      end
      S_GREEN: begin
        if (emgValid || expire) begin
          nextState = S_ALL_RED;
          timerLoad = 1'b1;
        end
      end
      S_EMG: begin
        if (!emgValid) begin
          nextState = S_ALL_RED;
          timerLoad = 1'b1;
        end
      end
`ifdef PED_PHASE_EN
      S_PED: begin
        if (expire) begin
          nextState = S_ALL_RED;
          timerLoad = 1'b1;
        end
      end
`endif
      default: begin
        nextState = S_ALL_RED;
        timerLoad = 1'b1;
      end
    endcase
  end

  always_comb begin
    nextGreen = '0;
    nextMode  = dayMode ? MODE_DAY : MODE_NIGHT;
    case (nextState)
      S_GREEN: nextGreen = {{(N_LANES-1){1'b0}}, 1'b1} << nextLanePtr;
      S_EMG: begin
        nextGreen = emgLane;
        nextMode  = MODE_EMG;
      end
`ifdef PED_PHASE_EN
      S_PED: nextMode = MODE_PED;
`endif
      default: ;
    endcase
  end

`ifdef PED_PHASE_EN
  // Entering PED consumes the request; requests during PED itself are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pedPending <= 1'b0;
      walkLights <= '0;
    end else begin
      walkLights <= (nextState == S_PED) ? '1 : '0;
      if (nextState == S_PED && state != S_PED) begin
        pedPending <= 1'b0;
      end else if (pedSignal && state != S_PED) begin
        pedPending <= 1'b1;
      end
    end
  end
`else
  logic unusedPed;
  assign unusedPed  = pedSignal;
  assign pedPending = 1'b0;
  assign walkLights = '0;
`endif

endmodule

// File: tb/tb_lane_phase_controller.sv
// tb/tb_lane_phase_controller.sv - scoreboard bench for lane_phase_controller
module tb_lane_phase_controller;

  localparam logic [1:0] DAY   = 2'b00;
  localparam logic [1:0] NIGHT = 2'b01;
  localparam logic [1:0] EMG   = 2'b10;
  localparam logic [1:0] PED   = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  hoursIn = 5'd12;
  logic        pedSignal = 1'b0;
  logic        emgSignal = 1'b0;
  logic [7:0]  emgLane = 8'h00;
  logic [63:0] laneCounts = '0;
  logic [7:0]  greenLights;
  logic [7:0]  walkLights;
  logic [1:0]  trafficMode;
  logic [6:0]  currentCount;

  always #5 clk = ~clk;

  lane_phase_controller dut (
    .clk          (clk),
    .rst          (rst),
    .hoursIn      (hoursIn),
    .pedSignal    (pedSignal),
    .emgSignal    (emgSignal),
    .emgLane      (emgLane),
    .laneCounts   (laneCounts),
    .greenLights  (greenLights),
    .walkLights   (walkLights),
    .trafficMode  (trafficMode),
    .currentCount (currentCount)
  );

  typedef struct {
    string      tag;
    logic [7:0] g;
    logic [7:0] w;
    logic [1:0] m;
    logic [6:0] c;
  } expT;

  typedef struct {
    logic [4:0] hours;
    logic [7:0] cnt;
    logic [1:0] mode;
    int         t;
  } vecT;

  expT sb[$];
  vecT vecs[11];
  int  checks = 0;
  int  errors = 0;

  task automatic pushPhase(input string tag, input int n, input logic [7:0] g,
                           input logic [7:0] w, input logic [1:0] m,
                           input int start, input bit dec);
    expT e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.g   = g;
      e.w   = w;
      e.m   = m;
      e.c   = 7'(dec ? start - i : start);
      sb.push_back(e);
    end
  endtask

  task automatic checkNow(input expT e);
    checks++;
    if (greenLights !== e.g || walkLights !== e.w || trafficMode !== e.m || currentCount !== e.c) begin
      errors++;
      $display("FAIL %s: got green=%h walk=%h mode=%b count=%0d, expected green=%h walk=%h mode=%b count=%0d",
               e.tag, greenLights, walkLights, trafficMode, currentCount, e.g, e.w, e.m, e.c);
    end
  endtask

  task automatic drainOne();
    expT e;
    @(negedge clk);
    e = sb.pop_front();
    checkNow(e);
  endtask

  task automatic drainAll();
    while (sb.size() > 0) drainOne();
  endtask

  // The reset-state cycle is the first of the three clearance cycles.
  task automatic startReset(input logic [1:0] m);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    pushPhase("reset", 1, 8'h00, 8'h00, DAY, 3, 1'b0);
    drainAll();
    rst = 1'b1;
    pushPhase("clear_init", 2, 8'h00, 8'h00, m, 2, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    expT r;

    vecs[0]  = '{5'd12, 8'h10, DAY,   12};
    vecs[1]  = '{5'd12, 8'hFF, DAY,   60};
    vecs[2]  = '{5'd12, 8'h00, DAY,    8};
    vecs[3]  = '{5'd6,  8'h03, DAY,    8};
    vecs[4]  = '{5'd21, 8'h07, DAY,    9};
    vecs[5]  = '{5'd12, 8'hD0, DAY,   60};
    vecs[6]  = '{5'd22, 8'h10, NIGHT,  8};
    vecs[7]  = '{5'd5,  8'h01, NIGHT,  4};
    vecs[8]  = '{5'd24, 8'h08, NIGHT,  6};
    vecs[9]  = '{5'd31, 8'hEC, NIGHT, 60};
    vecs[10] = '{5'd0,  8'hDC, NIGHT, 59};

    // Green-time table: lane 0 served first after each reset.
    for (int i = 0; i < 11; i++) begin
      hoursIn    = vecs[i].hours;
      laneCounts = {8{vecs[i].cnt}};
      startReset(vecs[i].mode);
      pushPhase($sformatf("vec%0d_green", i), vecs[i].t, 8'h01, 8'h00, vecs[i].mode, vecs[i].t, 1'b1);
      pushPhase($sformatf("vec%0d_clear", i), 3, 8'h00, 8'h00, vecs[i].mode, 3, 1'b1);
      drainAll();
    end

    // Night: only lane 3 occupied, then every lane empty.
    hoursIn    = 5'd22;
    laneCounts = 64'h0000_0000_0800_0000;
    startReset(NIGHT);
    pushPhase("night_l3a", 6, 8'h08, 8'h00, NIGHT, 6, 1'b1);
    pushPhase("night_clr", 3, 8'h00, 8'h00, NIGHT, 3, 1'b1);
    pushPhase("night_l3b", 6, 8'h08, 8'h00, NIGHT, 6, 1'b1);
    drainAll();
    laneCounts = '0;
    for (int i = 0; i < 4; i++) pushPhase("night_idle", 3, 8'h00, 8'h00, NIGHT, 3, 1'b1);
    drainAll();

    // Emergency preemption during lane 0 green.
    hoursIn    = 5'd12;
    laneCounts = {8{8'h10}};
    startReset(DAY);
    pushPhase("emg_g0", 5, 8'h01, 8'h00, DAY, 12, 1'b1);
    drainAll();
    emgSignal = 1'b1;
    emgLane   = 8'h00;
    pushPhase("emg_zero_lane", 2, 8'h01, 8'h00, DAY, 7, 1'b1);
    drainAll();
    emgLane = 8'h08;
    pushPhase("emg_abort_clr", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
    pushPhase("emg_active", 3, 8'h08, 8'h00, EMG, 0, 1'b0);
    drainAll();
    emgLane = 8'h30;
    pushPhase("emg_lane_upd", 2, 8'h30, 8'h00, EMG, 0, 1'b0);
    drainAll();
    emgSignal = 1'b0;
    pushPhase("emg_rel_clr", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
    pushPhase("emg_resume_g1", 4, 8'h02, 8'h00, DAY, 12, 1'b1);
    drainAll();
    emgSignal = 1'b1;
    emgLane   = 8'h08;
    pushPhase("emg2_clr", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
    pushPhase("emg2_active", 2, 8'h08, 8'h00, EMG, 0, 1'b0);
    drainAll();

    // Asynchronous reset between edges while in EMG.
    #2;
    rst = 1'b0;
    #1;
    r.tag = "async_reset";
    r.g = 8'h00; r.w = 8'h00; r.m = DAY; r.c = 7'd3;
    checkNow(r);
    emgSignal = 1'b0;
    emgLane   = 8'h00;
    startReset(DAY);
    pushPhase("post_rst_g0", 12, 8'h01, 8'h00, DAY, 12, 1'b1);
    pushPhase("post_rst_clr", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
    drainAll();

    // Round robin with a pedestrian pulse during lane 2 green.
    startReset(DAY);
    pushPhase("rr_g0", 12, 8'h01, 8'h00, DAY, 12, 1'b1);
    pushPhase("rr_clr0", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
    pushPhase("rr_g1", 12, 8'h02, 8'h00, DAY, 12, 1'b1);
    pushPhase("rr_clr1", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
    pushPhase("rr_g2a", 4, 8'h04, 8'h00, DAY, 12, 1'b1);
    drainAll();
    pushPhase("rr_g2b", 8, 8'h04, 8'h00, DAY, 8, 1'b1);
    pedSignal = 1'b1;
    drainOne();
    pedSignal = 1'b0;
    drainAll();
    pushPhase("rr_clr2", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
`ifdef PED_PHASE_EN
    pushPhase("ped_walk", 10, 8'h00, 8'hFF, PED, 10, 1'b1);
    pushPhase("ped_clr", 3, 8'h00, 8'h00, DAY, 3, 1'b1);
`endif
    pushPhase("rr_g3", 12, 8'h08, 8'h00, DAY, 12, 1'b1);
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
